// File: rtl/rcc_pkg.sv
// Shared constants for the ripple-carry counter.
`timescale 1ns/1ps
package rcc_pkg;

    localparam int unsigned RCC_DEFAULT_WIDTH = 4;
    localparam int unsigned RCC_MAX_WIDTH     = 32;

endpackage : rcc_pkg

// File: rtl/t_ff.sv
// Negedge toggle flip-flop with synchronous active-high reset; a single stage of the counter.
`timescale 1ns/1ps
module t_ff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    // Toggle on t, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (t) begin
            q_d = ~q_q;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : t_ff

// File: rtl/ripple_carry_counter.sv
// Free-running negedge up-counter built from a chain of toggle flops with a rippling AND carry.
// Optional terminal-count output tc is enabled by defining RCC_TC_OUT_EN.
`timescale 1ns/1ps
module ripple_carry_counter
    import rcc_pkg::*;
#(
    parameter int unsigned WIDTH = RCC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
`ifdef RCC_TC_OUT_EN
    ,
    output logic             tc
`endif
);

    if ((WIDTH == 0) || (WIDTH > RCC_MAX_WIDTH)) begin : g_bad_width
        $error("ripple_carry_counter: WIDTH %0d outside 1..%0d", WIDTH, RCC_MAX_WIDTH);
    end

    logic [WIDTH-1:0] tgl;

    // Stage i toggles only when every lower stage is 1.
    always_comb begin
        tgl    = '0;
        tgl[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            tgl[i] = tgl[i-1] & q[i-1];
        end
    end

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_stage
        t_ff u_t_ff (
            .clk   (clk),
            .reset (reset),
            .t     (tgl[gi]),
            .q     (q[gi])
        );
    end

`ifdef RCC_TC_OUT_EN
    // Decoded from the flops only, so it settles together with q and is 0 out of reset.
    assign tc = &q;
`endif

endmodule : ripple_carry_counter

// File: tb/tb_ripple_carry_counter.sv
// Directed bench for ripple_carry_counter: WIDTH 4 vector table plus WIDTH 1 and 8 instances.
`timescale 1ns/1ps
module tb_ripple_carry_counter;

    typedef struct {
        logic       rst;
        logic [3:0] q;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       rst_w1;
    logic       rst_w8;
    logic [3:0] q4;
    logic [0:0] q1;
    logic [7:0] q8;
`ifdef RCC_TC_OUT_EN
    logic       tc4;
    logic       tc1;
    logic       tc8;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tab[$];

    ripple_carry_counter #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .q     (q4)
`ifdef RCC_TC_OUT_EN
        , .tc  (tc4)
`endif
    );

    ripple_carry_counter #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .reset (rst_w1),
        .q     (q1)
`ifdef RCC_TC_OUT_EN
        , .tc  (tc1)
`endif
    );

    ripple_carry_counter #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (rst_w8),
        .q     (q8)
`ifdef RCC_TC_OUT_EN
        , .tc  (tc8)
`endif
    );

    // Low first, falling edges at 100, 200, 300 ... ns.
    initial begin
        clk = 1'b0;
        forever begin
            #50 clk = 1'b1;
            #50 clk = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] qv);
        vec_t v;
        v.rst = r;
        v.q   = qv;
        tab.push_back(v);
    endfunction

    // Drive reset for the coming edge, then sample just after it.
    task automatic step4(input logic r, input logic [3:0] exp_q);
        reset = r;
        @(negedge clk);
        #1;
        check("q4", 32'(q4), 32'(exp_q));
`ifdef RCC_TC_OUT_EN
        check("tc4", 32'(tc4), 32'(exp_q == 4'hF));
`endif
    endtask

    initial begin
        reset  = 1'b1;
        rst_w1 = 1'b1;
        rst_w8 = 1'b1;

        // Edge 100: reset; edges 200..400 count 1..3.
        add(1'b1, 4'h0);
        add(1'b0, 4'h1);
        add(1'b0, 4'h2);
        add(1'b0, 4'h3);
        // Edges 500..1600 count 4..F, then wrap to 0 at 1700, reach 7 at 2400.
        add(1'b0, 4'h4); add(1'b0, 4'h5); add(1'b0, 4'h6); add(1'b0, 4'h7);
        add(1'b0, 4'h8); add(1'b0, 4'h9); add(1'b0, 4'hA); add(1'b0, 4'hB);
        add(1'b0, 4'hC); add(1'b0, 4'hD); add(1'b0, 4'hE); add(1'b0, 4'hF);
        add(1'b0, 4'h0); add(1'b0, 4'h1); add(1'b0, 4'h2); add(1'b0, 4'h3);
        add(1'b0, 4'h4); add(1'b0, 4'h5); add(1'b0, 4'h6); add(1'b0, 4'h7);
        // Run up to F again, then reset on the all-ones value.
        add(1'b0, 4'h8); add(1'b0, 4'h9); add(1'b0, 4'hA); add(1'b0, 4'hB);
        add(1'b0, 4'hC); add(1'b0, 4'hD); add(1'b0, 4'hE); add(1'b0, 4'hF);
        add(1'b1, 4'h0); add(1'b0, 4'h1); add(1'b0, 4'h2);
        // Reset held for five edges, then release.
        add(1'b1, 4'h0); add(1'b1, 4'h0); add(1'b1, 4'h0); add(1'b1, 4'h0); add(1'b1, 4'h0);
        add(1'b0, 4'h1); add(1'b0, 4'h2);

        for (int i = 0; i < tab.size(); i++) begin
            if (i == 4) begin
                // Short pulse 440..444 ns between falling edges must be ignored.
                reset = 1'b0;
                #(440 - $time);
                reset = 1'b1;
                #4;
                reset = 1'b0;
            end
            step4(tab[i].rst, tab[i].q);
        end

        // Narrow and wide builds: one reset edge, then free run past the 8-bit wrap.
        @(negedge clk);
        #1;
        check("q1_reset", 32'(q1), 32'd0);
        check("q8_reset", 32'(q8), 32'd0);
        rst_w1 = 1'b0;
        rst_w8 = 1'b0;
        for (int k = 1; k <= 257; k++) begin
            logic [7:0] exp8;
            logic [0:0] exp1;
            exp8 = 8'(k);
            exp1 = 1'(k);
            @(negedge clk);
            #1;
            check("q8", 32'(q8), 32'(exp8));
            if (k <= 4) begin
                check("q1", 32'(q1), 32'(exp1));
            end
`ifdef RCC_TC_OUT_EN
            check("tc8", 32'(tc8), 32'(exp8 == 8'hFF));
            if (k <= 4) begin
                check("tc1", 32'(tc1), 32'(exp1));
            end
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ripple_carry_counter
